mod3_serial_checker: RTL and testbench

Sequencing controller for the serial divisible-by-three residue FSM. Accepts a parallel word on a start handshake and feeds it MSB-first into a 3-state residue machine, one bit per clock. Reports divisibility and the remainder with a one-cycle done pulse. Sits in front of the divide-by-3 datapath so that a single residue machine can be shared by successive parallel operands.

---
 rtl/mod3_serial_checker_if.sv | 22 ++
 rtl/mod3_serial_checker.sv | 93 +++++++++
 tb/tb_mod3_serial_checker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mod3_serial_checker_if.sv
// Handshake and result bundle between an operand source and the mod-3 serial checker.
// The source drives start/din; the checker returns status and the residue result.
interface mod3_serial_checker_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic             divisible;
  logic [1:0]       remainder;

  modport master (
    output start, din,
    input  busy, done, divisible, remainder
  );

  modport slave (
    input  start, din,
    output busy, done, divisible, remainder
  );
endinterface

// File: rtl/mod3_serial_checker.sv
// Sequencer feeding a parallel operand MSB-first through a 3-state residue machine.
// Reports operand mod 3 and divisibility with a one-cycle done pulse.
module mod3_serial_checker #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   RESET,
  mod3_serial_checker_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [1:0]       r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_divisible;
  logic [1:0]       r_remainder;
  logic [1:0]       w_res_next;

  // Residue after appending the current MSB: (2*r + bit) mod 3
  always_comb begin
    w_res_next = 2'd0;
    case ({r_res, r_sr[WIDTH-1]})
      3'b000:  w_res_next = 2'd0;
      3'b001:  w_res_next = 2'd1;
      3'b010:  w_res_next = 2'd2;
      3'b011:  w_res_next = 2'd0;
      3'b100:  w_res_next = 2'd1;
      3'b101:  w_res_next = 2'd2;
      default: w_res_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_sr        <= '0;
      r_res       <= 2'd0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_divisible <= 1'b0;
      r_remainder <= 2'd0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          // DONE accepts a new operand exactly like IDLE for back-to-back use
          if (bus.start) begin
            r_sr    <= bus.din;
            r_res   <= 2'd0;
            r_cnt   <= CNT_W'(WIDTH);
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_res <= w_res_next;
          r_sr  <= {r_sr[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_remainder <= w_res_next;
            r_divisible <= (w_res_next == 2'd0);
            r_state     <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.divisible = r_divisible;
  assign bus.remainder = r_remainder;
endmodule

// File: tb/tb_mod3_serial_checker.sv
// Directed and randomized bench for mod3_serial_checker; expected results come from
// integer modulo on the operand value and the documented cycle timing.
module tb_mod3_serial_checker;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic RESET;
  int   checks;
  int   errors;

  mod3_serial_checker_if #(.WIDTH(WIDTH)) bus ();

  mod3_serial_checker #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Caller has start/din set up for the accepting edge. Optionally pulses start mid-shift
  // (must be ignored) and optionally raises start in the DONE cycle for a back-to-back operand.
  task automatic check_op(input logic [WIDTH-1:0] v, input int inj_at,
                          input logic [WIDTH-1:0] inj_din,
                          input bit next_start, input logic [WIDTH-1:0] next_din);
    int unsigned exp_rem;
    exp_rem = int'(v) % 3;
    for (int i = 0; i < int'(WIDTH); i++) begin
      step();
      bus.start = 1'b0;
      if (i == inj_at) begin
        bus.start = 1'b1;
        bus.din   = inj_din;
      end
      chk("busy_shift", 32'(bus.busy), 32'd1);
      chk("done_shift", 32'(bus.done), 32'd0);
    end
    step();
    bus.start = 1'b0;
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_done", 32'(bus.busy), 32'd0);
    chk("remainder", 32'(bus.remainder), 32'(exp_rem));
    chk("divisible", 32'(bus.divisible), (exp_rem == 0) ? 32'd1 : 32'd0);
    if (next_start) begin
      bus.start = 1'b1;
      bus.din   = next_din;
    end else begin
      step();
      chk("done_single", 32'(bus.done), 32'd0);
      chk("busy_idle", 32'(bus.busy), 32'd0);
      chk("rem_held", 32'(bus.remainder), 32'(exp_rem));
      chk("div_held", 32'(bus.divisible), (exp_rem == 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] v);
    bus.start = 1'b1;
    bus.din   = v;
    check_op(v, -1, '0, 1'b0, '0);
  endtask

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int pulses;
    checks    = 0;
    errors    = 0;
    bus.start = 1'b0;
    bus.din   = '0;
    RESET     = 1'b1;
    step();
    step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_div", 32'(bus.divisible), 32'd0);
    chk("rst_rem", 32'(bus.remainder), 32'd0);
    RESET = 1'b0;
    step();

    // Basic operand, then results held in IDLE for a few cycles
    run_op(WIDTH'(9));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_hold_rem", 32'(bus.remainder), 32'd0);
      chk("idle_hold_div", 32'(bus.divisible), 32'd1);
    end

    run_op(WIDTH'(10));
    run_op(WIDTH'(11));
    run_op(WIDTH'(8'hFF));
    run_op(WIDTH'(0));

    // Start pulsed in SHIFT (din=6) is ignored; result is for 7
    bus.start = 1'b1;
    bus.din   = WIDTH'(7);
    check_op(WIDTH'(7), 2, WIDTH'(6), 1'b0, '0);

    // Back-to-back: 7 then 12 accepted in the DONE cycle
    bus.start = 1'b1;
    bus.din   = WIDTH'(7);
    check_op(WIDTH'(7), -1, '0, 1'b1, WIDTH'(12));
    check_op(WIDTH'(12), -1, '0, 1'b0, '0);

    // Reset during the fourth SHIFT cycle discards the operand
    bus.start = 1'b1;
    bus.din   = WIDTH'(5);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_div", 32'(bus.divisible), 32'd0);
    chk("mid_rst_rem", 32'(bus.remainder), 32'd0);
    pulses = 0;
    for (int i = 0; i < 2 * int'(WIDTH); i++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    chk("no_done_after_rst", 32'(pulses), 32'd0);

    // Exhaustive sweep
    for (int v = 0; v < (1 << WIDTH); v++) run_op(WIDTH'(v));

    // Randomized back-to-back chains
    for (int n = 0; n < 20; n++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      bus.start = 1'b1;
      bus.din   = a;
      check_op(a, -1, '0, 1'b1, b);
      check_op(b, int'($urandom_range(0, WIDTH - 2)), WIDTH'($urandom), 1'b0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
